// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and the divide-by-zero quotient value.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Quotient produced by restoring division when the divisor is zero
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    // Bit 1 of the op field selects divide, bit 0 selects the unsigned form
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes and to restore the sign of the final results; wraps modulo 2^W.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_in,
    input  logic         negate,
    output logic [W-1:0] value_out
);

    // Pass through or negate depending on the requested sign
    always_comb begin
        value_out = negate ? ({W{1'b0}} - value_in) : value_in;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step is
// performed per clock; signed operations run on magnitudes and the signs
// are restored as the results are written into HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITER + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   addend_q, addend_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_eff;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_acc;

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Decide which operands are treated as signed; a zero divisor forces the
    // raw unsigned view so the result is all-ones quotient and raw dividend
    always_comb begin
        signed_eff = op_is_signed(op) && !(op_is_div(op) && (operand_b == '0));
        sign_a     = signed_eff & operand_a[WIDTH-1];
        sign_b     = signed_eff & operand_b[WIDTH-1];
    end

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (
        .value_in  (operand_a),
        .negate    (sign_a),
        .value_out (abs_a)
    );

    mdu_sign_fix #(.W(WIDTH)) u_abs_b (
        .value_in  (operand_b),
        .negate    (sign_b),
        .value_out (abs_b)
    );

    // One iteration of either algorithm on the shared 2*WIDTH accumulator
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, addend_q};
        end
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge  = rem_sh >= {1'b0, addend_q};
        rem_sub = rem_sh[WIDTH-1:0] - addend_q;
        if (rem_ge) begin
            div_next = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        step_acc = is_div_q ? div_next : mul_next;
    end

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value_in  (step_acc),
        .negate    (neg_q),
        .value_out (prod_fixed)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value_in  (step_acc[WIDTH-1:0]),
        .negate    (neg_q),
        .value_out (quo_fixed)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value_in  (step_acc[2*WIDTH-1:WIDTH]),
        .negate    (rem_neg_q),
        .value_out (rem_fixed)
    );

    // Controller: launch from IDLE, iterate in RUN, commit HI/LO on the final
    // step so they are visible in FIN together with the done pulse
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        addend_d  = addend_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op_is_div(op);
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a & op_is_div(op);
                    cnt_d     = CNT_W'(ITER);
                    if (op_is_div(op)) begin
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                        addend_d = abs_b;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, abs_b};
                        addend_d = abs_a;
                    end
                    state_d = RUN;
                end else begin
                    if (hi_we) begin
                        hi_d = wr_data;
                    end
                    if (lo_we) begin
                        lo_d = wr_data;
                    end
                end
            end

            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                    if (is_div_q) begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end else begin
                        hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                        lo_d = prod_fixed[WIDTH-1:0];
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            addend_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            addend_q  <= addend_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Status and register outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == FIN);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pairs are queued when
// an operation is launched and compared when the unit pulses done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t exp_q[$];
    int   check_count = 0;
    int   error_count = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it when it disagrees
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model of the architectural HI/LO result
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.tag = tag;
        case (o)
            OP_MULT: begin
                p = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'b0) begin
                    e.hi = a;
                    e.lo = DIV0_LO;
                end else if (o == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                checkOutput({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            end
        end
    end

    // Launch one operation and track busy/done timing.
    // mid_action: 0 none, 1 MTHI while busy, 2 re-pulse start while busy,
    // 3 lo_we together with start
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int mid_action, input string tag);
        int busy_cycles;
        int waited;
        exp_q.push_back(model(o, a, b, tag));
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        if (mid_action == 3) begin
            lo_we   = 1'b1;
            wr_data = 32'h0000_9999;
        end
        @(negedge clk);
        start     = 1'b0;
        lo_we     = 1'b0;
        operand_a = $urandom();
        operand_b = $urandom();
        busy_cycles = 0;
        waited      = 0;
        while (!done && waited < 100) begin
            if (busy) busy_cycles++;
            hi_we = (mid_action == 1) && (busy_cycles == 5);
            if (hi_we) wr_data = 32'h0000_DEAD;
            start = (mid_action == 2) && (busy_cycles == 5);
            if (start) begin
                op        = OP_MULTU;
                operand_a = 32'd5;
                operand_b = 32'd5;
            end
            @(negedge clk);
            hi_we = 1'b0;
            start = 1'b0;
            waited++;
        end
        if (waited >= 100) begin
            checkOutput({tag, "_timeout"}, 64'(0), 64'(1));
            exp_q.delete();
        end
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(32));
        @(negedge clk);
        checkOutput({tag, "_done_single"}, 64'(done), 64'(0));
        checkOutput({tag, "_idle"}, 64'(busy), 64'(0));
        checkOutput({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Test sequence
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wr_data   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_hi", 64'(hi), 64'(0));
        checkOutput("reset_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;

        $display("[TB] MTHI/MTLO in IDLE");
        @(negedge clk);
        hi_we = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("mthi", 64'(hi), 64'(32'h1234));
        lo_we = 1'b1; wr_data = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo", 64'(lo), 64'(32'h5678));
        checkOutput("mtlo_hi_kept", 64'(hi), 64'(32'h1234));
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0000_ABCD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("mt_both_hi", 64'(hi), 64'(32'hABCD));
        checkOutput("mt_both_lo", 64'(lo), 64'(32'hABCD));

        $display("[TB] arithmetic operations");
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'd6, 1, "mult_neg7x6_mthi_busy");
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 2, "div_neg7by2_restart");
        applyStimulus(OP_DIVU, 32'd100, 32'd0, 0, "divu_by_zero");
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, "div_neg_by_zero");
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_by_neg1");
        applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7by_neg2");
        applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, "mult_min_sq");
        applyStimulus(OP_DIVU, 32'hDEAD_BEEF, 32'd1234, 0, "divu_mixed");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), $urandom(), $urandom(), 0, "random_op");
        end

        $display("[TB] reset during RUN");
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; operand_a = 32'd1000; operand_b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("pre_abort_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_hi", 64'(hi), 64'(0));
        checkOutput("abort_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OP_MULTU, 32'd3, 32'd4, 0, "multu_3x4_after_reset");

        $display("[TB] start together with lo_we");
        applyStimulus(OP_MULTU, 32'd7, 32'd9, 3, "start_wins_lo_we");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that consumes the two register-file read operands for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers. MFHI/MFLO read them combinationally, and MTHI/MTLO write them.
- Sits beside the ALU in the execute path. Control stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  in  WIDTH  rs value (multiplicand / dividend)
- operand_b  in  WIDTH  rt value (multiplier / divisor)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wr_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal iteration registers=0. A reset asserted mid-operation aborts the operation, and no HI/LO update occurs.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge t latches |operand_a|, |operand_b| and the result signs. Absolute values are taken only for ops 00 and 10; unsigned ops use the raw values.
  - The iteration counter is loaded with ITER. Next state is RUN.
- RUN:
  - busy=1.
  - Each edge performs one step. MUL: shift-add, 64-bit accumulator. DIV: restoring shift-subtract, producing the quotient bit and partial remainder.
  - The counter decrements. When it reaches 0, next state is FIN.
- FIN:
  - busy=0. HI/LO are written on entry, with done=1 for that single cycle. Next state is IDLE.
  - MUL: {hi,lo} = signed or unsigned 64-bit product.
  - DIV: lo = quotient, hi = remainder.
- Latency: start at edge t gives busy=1 for cycles t+1..t+32. HI/LO update and done=1 occur at edge t+33.
- Sign fixup:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - All arithmetic wraps modulo 2^WIDTH, so DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (operand_b=0, op 10/11): same latency, no special fast path. Result is lo=0xFFFFFFFF, hi=operand_a (raw, unsigned view). This is the natural result of restoring division on unsigned magnitudes; for DIV the sign fixup is suppressed when the divisor is zero.
- Ignored inputs:
  - start is ignored in RUN and FIN.
  - hi_we/lo_we are ignored in RUN and FIN, so no corruption of an in-flight result.
- MTHI/MTLO in IDLE: hi<=wr_data when hi_we, lo<=wr_data when lo_we. Both may fire in the same cycle, in which case both registers take wr_data.
- start together with hi_we/lo_we in IDLE: start wins and the writes are dropped.
- HI/LO hold their values between operations. Operand inputs need not be held stable after the start edge.

Decomposition:
- Package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, RUN, FIN
  - constant DIV0_LO = 32'hFFFFFFFF
- Sub-module mdu_sign_fix: combinational conditional negate, instantiated for operand abs and result fixup. Everything else stays in one module.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles; done pulses once at cycle 33.
- MULT -7 × 6: hi=0xFFFFFFFF, lo=0xFFFFFFD6. Then DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0: lo=0xFFFFFFFF, hi=100, normal latency. Also DIV 0x80000000 / -1: lo=0x80000000, hi=0.
- MTHI 0x1234 and MTLO 0x5678 in IDLE are visible the next cycle. MTHI issued while busy leaves hi equal to the operation's result at done. start re-pulsed mid-RUN does not restart the count.
- Reset at RUN iteration 10: busy=0, hi=lo=0 immediately. A subsequent MULTU 3 × 4 completes normally with lo=12.
- start together with lo_we in IDLE: the operation runs, and lo equals the product, not wr_data.
